// File: rtl/pfifo_pop_reader_if.sv
// Pop-side FIFO handshake plus downstream beat stream for pfifo_pop_reader.
// Signal names keep the reader's point of view (i_ = into the reader, o_ = out of it).
interface pfifo_pop_reader_if;
    logic         o_pop_permit;
    logic [4:0]   o_pop_amount;
    logic         i_pop_enable;
    logic [255:0] i_pop_data;
    logic [255:0] o_data;
    logic [4:0]   o_bytes;
    logic         o_valid;
    logic         o_last;
    logic         i_ready;

    modport master (
        output o_pop_permit, o_pop_amount, o_data, o_bytes, o_valid, o_last,
        input  i_pop_enable, i_pop_data, i_ready
    );

    modport slave (
        input  o_pop_permit, o_pop_amount, o_data, o_bytes, o_valid, o_last,
        output i_pop_enable, i_pop_data, i_ready
    );
endinterface

// File: rtl/pfifo_pop_reader.sv
// Read-side master for the parallel byte FIFO: pops variable-size chunks for a
// byte-count command and re-presents each popped word as a registered valid/ready beat.
module pfifo_pop_reader (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rstn,
    input  logic                      i_start,
    input  logic [15:0]               i_total_bytes,
    input  logic [4:0]                i_chunk_max,
    input  logic                      i_abort,
    pfifo_pop_reader_if.master        bus,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [15:0]   r_rem;
    logic [4:0]    r_cmax;
    logic [255:0]  r_data;
    logic [4:0]    r_bytes;
    logic          r_valid;
    logic          r_last;

    logic [15:0]   w_remM1;
    logic [15:0]   w_remNext;
    logic [4:0]    w_amt;
    logic          w_permit;
    logic          w_pop;
    logic          w_handshake;

    // A pop is only permitted when the output register is free or being drained this cycle.
    always_comb begin
        w_remM1     = r_rem - 16'd1;
        w_amt       = (w_remM1 > {11'd0, r_cmax}) ? r_cmax : w_remM1[4:0];
        w_remNext   = r_rem - {11'd0, w_amt} - 16'd1;
        w_permit    = (r_state == ST_RUN) && (r_rem != 16'd0) && (!r_valid || bus.i_ready);
        w_pop       = w_permit && bus.i_pop_enable;
        w_handshake = r_valid && bus.i_ready;
    end

    always_comb begin
        w_stateNext = r_state;
        if (i_abort) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_stateNext = (i_total_bytes == 16'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pop && (w_remNext == 16'd0)) begin
                        w_stateNext = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_handshake && r_last) begin
                        w_stateNext = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_stateNext = ST_IDLE;
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Abort drops any pop landing in the same cycle; the FIFO has already released it.
    always_ff @(posedge i_core_clk) begin
        if (!i_rx_rstn) begin
            r_rem   <= 16'd0;
            r_cmax  <= 5'd0;
            r_data  <= 256'd0;
            r_bytes <= 5'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_abort) begin
            r_rem   <= 16'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_data  <= bus.i_pop_data;
                r_bytes <= w_amt;
                r_valid <= 1'b1;
                r_last  <= (w_remNext == 16'd0);
                r_rem   <= w_remNext;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if ((r_state == ST_IDLE) && i_start) begin
                r_rem  <= i_total_bytes;
                r_cmax <= i_chunk_max;
            end
        end
    end

    assign bus.o_pop_permit = w_permit;
    assign bus.o_pop_amount = (r_state == ST_RUN) ? w_amt : 5'd0;
    assign bus.o_data       = r_data;
    assign bus.o_bytes      = r_bytes;
    assign bus.o_valid      = r_valid;
    assign bus.o_last       = r_last;
    assign o_busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done           = (r_state == ST_DONE);

endmodule

// File: tb/tb_pfifo_pop_reader.sv
// Bench for pfifo_pop_reader: byte-array FIFO model, command-level reference model
// checked every cycle, directed scenarios with literal expectations, then random commands.
module tb_pfifo_pop_reader;

    localparam int MEMSZ = 4096;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [15:0] total;
    logic [4:0]  cmax;
    logic        abort;
    logic        busy;
    logic        done;

    pfifo_pop_reader_if bus ();

    pfifo_pop_reader dut (
        .i_core_clk    (clk),
        .i_rx_rstn     (rstn),
        .i_start       (start),
        .i_total_bytes (total),
        .i_chunk_max   (cmax),
        .i_abort       (abort),
        .bus           (bus.master),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    // FIFO model: preloaded byte memory, level = wrPtr - rdPtr.
    logic [7:0] mem [MEMSZ];
    int wrPtr = 0;
    int rdPtr = 0;

    assign bus.i_pop_enable = bus.o_pop_permit && ((wrPtr - rdPtr) > int'(bus.o_pop_amount));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state at command level.
    bit           modelOn = 1'b0;
    bit           mActive = 1'b0;
    bit           mDone = 1'b0;
    int           mRem = 0;
    int           mChunk = 0;
    bit           mValid = 1'b0;
    bit           mLast = 1'b0;
    logic [255:0] mData = '0;
    int           mBytes = 0;

    int popAmtLog[$];
    int beatBytesLog[$];
    bit beatLastLog[$];
    int beatCycLog[$];
    int doneCount = 0;
    int doneCyc = 0;
    int validCount = 0;
    bit fifoPopPending = 1'b0;
    int fifoPopAmt = 0;

    function automatic logic [255:0] fifoWord(input int ptr);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[k*8 +: 8] = mem[(ptr + k) % MEMSZ];
        return w;
    endfunction

    function automatic bit modelIdle();
        return !mActive && !mDone;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkNum(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkWord(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs just before each rising edge: compare DUT to model, log, then advance the model.
    task automatic checkOutput();
        int expAmt;
        bit expPermit, mPop, hs, wasLast, idleNow;
        cyc++;
        expAmt = 0;
        if (mActive && mRem > 0) expAmt = ((mRem < mChunk + 1) ? mRem : mChunk + 1) - 1;
        expPermit = mActive && (mRem > 0) && (!mValid || bus.i_ready);
        if (modelOn) begin
            checkBit("pop_permit", bus.o_pop_permit, expPermit);
            checkNum("pop_amount", int'(bus.o_pop_amount), expAmt);
            checkBit("valid", bus.o_valid, mValid);
            checkBit("last", bus.o_last, mLast);
            checkNum("bytes", int'(bus.o_bytes), mBytes);
            checkWord("data", bus.o_data, mData);
            checkBit("busy", busy, mActive);
            checkBit("done", done, mDone);
        end
        if (bus.o_valid && bus.i_ready) begin
            beatBytesLog.push_back(int'(bus.o_bytes));
            beatLastLog.push_back(bus.o_last);
            beatCycLog.push_back(cyc);
        end
        if (bus.i_pop_enable) popAmtLog.push_back(int'(bus.o_pop_amount));
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (bus.o_valid) validCount++;
        fifoPopPending = bus.i_pop_enable;
        fifoPopAmt = int'(bus.o_pop_amount);

        if (!rstn) begin
            modelOn = 1'b1;
            mActive = 0; mDone = 0; mRem = 0; mChunk = 0;
            mValid = 0; mLast = 0; mData = '0; mBytes = 0;
        end else if (abort) begin
            mActive = 0; mDone = 0; mRem = 0; mValid = 0; mLast = 0;
        end else begin
            idleNow = !mActive && !mDone;
            mPop = expPermit && ((wrPtr - rdPtr) > expAmt);
            hs = mValid && bus.i_ready;
            wasLast = mLast;
            mDone = 1'b0;
            if (mPop) begin
                mData = fifoWord(rdPtr);
                mBytes = expAmt;
                mRem = mRem - expAmt - 1;
                mValid = 1'b1;
                mLast = (mRem == 0);
            end else if (hs) begin
                mValid = 1'b0;
                mLast = 1'b0;
                if (wasLast) begin
                    mActive = 1'b0;
                    mDone = 1'b1;
                end
            end
            if (idleNow && start) begin
                if (total == 16'd0) begin
                    mDone = 1'b1;
                end else begin
                    mActive = 1'b1;
                    mRem = int'(total);
                    mChunk = int'(cmax);
                end
            end
        end
    endtask

    task automatic cycleStep();
        #7;
        checkOutput();
        @(posedge clk);
        #1;
        if (fifoPopPending) rdPtr = rdPtr + fifoPopAmt + 1;
        bus.i_pop_data = fifoWord(rdPtr);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic applyStimulus(input bit st, input int tot, input int cm, input bit ab,
                                 input bit rdy, input int push, input bit rn);
        start = st;
        total = tot[15:0];
        cmax = cm[4:0];
        abort = ab;
        bus.i_ready = rdy;
        rstn = rn;
        wrPtr = wrPtr + push;
        cycleStep();
    endtask

    task automatic runRandom(input int budget, input int readyPct, input int pushMax,
                             input int abortPct, input int startPct, input string tag);
        int n, push;
        bit rdy, ab, st;
        n = 0;
        do begin
            rdy = ($urandom_range(0, 99) < readyPct);
            ab = (abortPct > 0) && ($urandom_range(0, 99) < abortPct);
            st = (startPct > 0) && ($urandom_range(0, 99) < startPct);
            push = ((wrPtr - rdPtr) < 1000) ? int'($urandom_range(0, pushMax)) : 0;
            applyStimulus(st, int'($urandom_range(0, 300)), int'($urandom_range(0, 31)), ab, rdy, push, 1'b1);
            n++;
        end while (!modelIdle() && n < budget);
        if (!modelIdle()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic clearLogs();
        popAmtLog.delete();
        beatBytesLog.delete();
        beatLastLog.delete();
        beatCycLog.delete();
        validCount = 0;
    endtask

    task automatic flushFifo();
        rdPtr = wrPtr;
        bus.i_pop_data = fifoWord(rdPtr);
    endtask

    function automatic int beatByteSum();
        int s = 0;
        foreach (beatBytesLog[i]) s += beatBytesLog[i] + 1;
        return s;
    endfunction

    initial begin
        int doneBefore, validBefore, level;
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        rstn = 1'b0; start = 1'b0; total = '0; cmax = '0; abort = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_pop_data = fifoWord(0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkWord("reset_data", bus.o_data, 256'd0);
        checkBit("reset_valid", bus.o_valid, 1'b0);
        checkBit("reset_busy", busy, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Streaming: 96 bytes preloaded, 70 requested in 32-byte chunks.
        flushFifo(); clearLogs();
        applyStimulus(1, 70, 31, 0, 1, 96, 1);
        runRandom(50, 100, 0, 0, 0, "stream");
        checkNum("stream_pops", popAmtLog.size(), 3);
        if (popAmtLog.size() == 3) begin
            checkNum("stream_amt0", popAmtLog[0], 31);
            checkNum("stream_amt1", popAmtLog[1], 31);
            checkNum("stream_amt2", popAmtLog[2], 5);
        end
        checkNum("stream_beats", beatBytesLog.size(), 3);
        if (beatBytesLog.size() == 3) begin
            checkNum("stream_bytes2", beatBytesLog[2], 5);
            checkBit("stream_last0", beatLastLog[0], 1'b0);
            checkBit("stream_last2", beatLastLog[2], 1'b1);
            checkNum("stream_b2b", beatCycLog[2] - beatCycLog[0], 2);
            checkNum("stream_done_lat", doneCyc - beatCycLog[2], 1);
        end

        // Backpressure: three stalled cycles hold the beat and block pops.
        flushFifo(); clearLogs();
        applyStimulus(1, 64, 15, 0, 1, 100, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkNum("bp_level", wrPtr - rdPtr, 84);
        for (int i = 0; i < 3; i++) begin
            bus.i_ready = 1'b0;
            #1;
            checkBit("bp_permit", bus.o_pop_permit, 1'b0);
            checkBit("bp_valid", bus.o_valid, 1'b1);
            checkNum("bp_bytes", int'(bus.o_bytes), 15);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
        end
        checkNum("bp_level_held", wrPtr - rdPtr, 84);
        runRandom(200, 100, 0, 0, 0, "bp");
        checkNum("bp_sum", beatByteSum(), 64);

        // Starvation: 4 bytes present, first pop needs 8.
        flushFifo(); clearLogs();
        applyStimulus(1, 10, 7, 0, 1, 4, 1);
        for (int i = 0; i < 4; i++) begin
            checkBit("starve_permit", bus.o_pop_permit, 1'b1);
            checkNum("starve_amount", int'(bus.o_pop_amount), 7);
            applyStimulus(0, 0, 0, 0, 1, 0, 1);
        end
        checkNum("starve_no_pop", popAmtLog.size(), 0);
        applyStimulus(0, 0, 0, 0, 1, 4, 1);
        runRandom(200, 100, 2, 0, 0, "starve");
        checkNum("starve_pops", popAmtLog.size(), 2);
        if (popAmtLog.size() == 2) begin
            checkNum("starve_amt0", popAmtLog[0], 7);
            checkNum("starve_amt1", popAmtLog[1], 1);
        end
        checkNum("starve_sum", beatByteSum(), 10);

        // Zero-length command.
        flushFifo(); clearLogs();
        doneBefore = doneCount;
        applyStimulus(1, 0, 5, 0, 1, 0, 1);
        checkBit("zero_done", done, 1'b1);
        checkBit("zero_busy", busy, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkNum("zero_done_count", doneCount - doneBefore, 1);
        checkNum("zero_valid", validCount, 0);

        // Ignored start while busy.
        flushFifo(); clearLogs();
        applyStimulus(1, 40, 7, 0, 1, 200, 1);
        applyStimulus(1, 100, 0, 0, 1, 0, 1);
        applyStimulus(1, 100, 0, 0, 1, 0, 1);
        runRandom(200, 100, 0, 0, 0, "ignore");
        checkNum("ignore_beats", beatBytesLog.size(), 5);
        checkNum("ignore_sum", beatByteSum(), 40);

        // Abort after the first beat.
        flushFifo(); clearLogs();
        applyStimulus(1, 64, 31, 0, 1, 128, 1);
        for (int i = 0; i < 20 && beatBytesLog.size() == 0; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkNum("abort_first_beat", (beatBytesLog.size() > 0) ? beatBytesLog[0] : -1, 31);
        doneBefore = doneCount;
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        checkBit("abort_valid", bus.o_valid, 1'b0);
        checkBit("abort_busy", busy, 1'b0);
        checkBit("abort_permit", bus.o_pop_permit, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkNum("abort_no_done", doneCount - doneBefore, 0);

        // Reset mid-run.
        flushFifo(); clearLogs();
        applyStimulus(1, 64, 15, 0, 1, 128, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkBit("rst_permit", bus.o_pop_permit, 1'b0);
        checkNum("rst_amount", int'(bus.o_pop_amount), 0);
        checkWord("rst_data", bus.o_data, 256'd0);
        checkNum("rst_bytes", int'(bus.o_bytes), 0);
        checkBit("rst_valid", bus.o_valid, 1'b0);
        checkBit("rst_last", bus.o_last, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_done", done, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);

        // Chunk limit of one byte per pop.
        flushFifo(); clearLogs();
        applyStimulus(1, 5, 0, 0, 1, 10, 1);
        runRandom(100, 100, 0, 0, 0, "chunk1");
        checkNum("chunk1_beats", beatBytesLog.size(), 5);
        if (beatBytesLog.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkNum("chunk1_bytes", beatBytesLog[i], 0);
                checkBit("chunk1_last", beatLastLog[i], i == 4);
            end
        end

        // Random commands with backpressure, starvation, aborts and stray starts.
        for (int c = 0; c < 25; c++) begin
            validBefore = int'($urandom_range(0, 150));
            level = ((wrPtr - rdPtr) < 1000) ? int'($urandom_range(0, 60)) : 0;
            applyStimulus(1, validBefore, int'($urandom_range(0, 31)), 0,
                          ($urandom_range(0, 1) == 1), level, 1);
            runRandom(1500, 60, 40, 2, 5, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
